// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock) feeding
// the seven-segment driver with packed BCD digits and leading-zero blank flags.
module product_bcd_converter #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [BIN_W-1:0]   shift_d;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   scratch_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [DIGITS-1:0]  blank_q;
  logic [DIGITS-1:0]  blank_d;
  logic               zero_run;

  // One double-dabble step: add-3 on every digit >= 5, then shift {scratch, shift} left.
  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
    scratch_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
    shift_d   = {shift_q[BIN_W-2:0], 1'b0};
    cnt_d     = cnt_q - CNT_W'(1);
  end

  // Leading-zero flags: a digit blanks only if it and every higher digit are zero.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run   = zero_run & (scratch_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_d;
          // Last shift: publish the result and return to IDLE.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= scratch_d;
            blank_q <= blank_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed cases plus random
// conversions compared against a decimal-arithmetic reference model.
module tb_product_bcd_converter;

  localparam int unsigned BIN_W  = 10;
  localparam int unsigned DIGITS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [BIN_W-1:0]     bin;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
  logic [DIGITS-1:0]    blank;

  int n_cmp = 0;
  int n_bad = 0;

  product_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, wanted 'h%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: digit i is a leading zero iff value < 10^i.
  function automatic logic [31:0] ref_blank(input int v);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 1; i < int'(DIGITS); i++) begin
      p = p * 10;
      r[i] = (v < p);
    end
    return r;
  endfunction

  // Called mid-cycle; start is sampled on the next rising edge.
  task automatic do_start(input int v);
    start = 1'b1;
    bin   = BIN_W'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = BIN_W'($urandom);
  endtask

  // Follows a conversion to its done cycle; optionally re-pulses start at cycle rk.
  task automatic expect_done(input string tag, input int v, input int rk, input int rv);
    bit seen;
    seen = 1'b0;
    for (int k = 1; k <= int'(BIN_W) + 6 && !seen; k++) begin
      @(negedge clk);
      if (k == rk + 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk({tag, ".lat"}, 32'(k), 32'(BIN_W + 1));
        chk({tag, ".bcd"}, 32'(bcd), ref_bcd(v));
        chk({tag, ".blank"}, 32'(blank), ref_blank(v));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      end else if (k == 1 || k == int'(BIN_W)) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
      end
      if (k == rk) begin
        start = 1'b1;
        bin   = BIN_W'(rv);
      end
    end
    if (!seen) chk({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  // Watches n cycles and checks that no done pulse appears.
  task automatic expect_quiet(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk({tag, ".no_done"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    int v, nv, gap;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.bcd", 32'(bcd), 32'h0000);
    chk("reset.blank", 32'(blank), 32'b1110);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);

    do_start(961);  expect_done("d961", 961, -1, 0);
    @(negedge clk); chk("d961.pulse_width", 32'(done), 32'd0);
    do_start(1023); expect_done("d1023", 1023, -1, 0);
    @(negedge clk);
    do_start(0);    expect_done("d0", 0, -1, 0);
    @(negedge clk);
    do_start(5);    expect_done("d5", 5, -1, 0);
    @(negedge clk);

    // A start while busy must be ignored and not queued.
    do_start(100);  expect_done("restart", 100, 4, 999);
    expect_quiet("restart", 15);

    // Start asserted in the done cycle chains a second conversion.
    do_start(42);   expect_done("b2b_a", 42, -1, 0);
    do_start(507);  expect_done("b2b_b", 507, -1, 0);
    @(negedge clk);

    // Asynchronous reset mid-conversion.
    do_start(777);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.bcd", 32'(bcd), 32'h0000);
    chk("abort.blank", 32'(blank), 32'b1110);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("abort", 15);
    do_start(12);   expect_done("post_abort", 12, -1, 0);
    @(negedge clk);

    // Random conversions, some chained back-to-back, some with idle gaps.
    v = int'($urandom_range(0, 1023));
    do_start(v);
    for (int t = 0; t < 40; t++) begin
      expect_done("rand", v, -1, 0);
      nv  = int'($urandom_range(0, 1023));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rand.gap_done", 32'(done), 32'd0);
      end
      v = nv;
      do_start(v);
    end
    expect_done("rand_last", v, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
